// File: rtl/cpu1_keys.sv
// Debounced key input peripheral with an Avalon-MM slave interface.
// Each raw active-low key is synchronized, debounced, and a debounced
// press (1->0) latches a sticky edge-capture bit that software clears by
// writing ones to it. Edge-capture bits gated by the irq mask raise irq.
//
// Register map (word address):
//   0  debounced key state (read-only)
//   1  irq mask            (read/write)
//   2  reads zero
//   3  edge capture        (read, write-1-to-clear)
module cpu1_keys #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] deb_prev_q, deb_prev_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    logic             wr_en;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] clr_mask;

    // Only the low WIDTH bits of writedata carry register content.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // Two-stage synchronizer for the asynchronous key inputs.
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
    end

    // Per-bit debounce: count consecutive cycles where the synced bit
    // disagrees with the debounced bit; accept the new value on the last one.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Press detection, sticky edge capture (set wins over clear) and mask write.
    always_comb begin
        wr_en      = chipselect & ~write_n;
        press      = deb_prev_q & ~deb_q;
        clr_mask   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        deb_prev_d = deb_q;
        edgecap_d  = (edgecap_q & ~clr_mask) | press;
        irqmask_d  = (wr_en && address == 2'd1) ? writedata[WIDTH-1:0] : irqmask_q;
    end

    // State registers; keys reset to released so reset release creates no press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            deb_q      <= '1;
            deb_prev_q <= '1;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Zero-wait-state read mux and level interrupt.
    always_comb begin
        case (address)
            2'd0:    readdata = 32'(deb_q);
            2'd1:    readdata = 32'(irqmask_q);
            2'd3:    readdata = 32'(edgecap_q);
            default: readdata = '0;
        endcase
        irq = |(edgecap_q & irqmask_q);
    end

endmodule

// File: tb/tb_cpu1_keys.sv
// Scoreboard bench for cpu1_keys: a driver applies stimulus and pushes the
// expected bus response computed by a cycle-level reference model; a monitor
// on the falling edge pops and compares against the DUT outputs.
module tb_cpu1_keys;

    localparam int W   = 4;
    localparam int DEB = 4;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] readdata;
    logic        irq;

    cpu1_keys #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rd_valid;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: key values seen after each clock edge.
    logic [W-1:0] m_s1, m_s2, m_deb, m_prev, m_ec, m_mask;
    int           m_run [W];

    // Inputs currently applied (what the next edge will sample).
    logic         cur_rst;
    logic [W-1:0] cur_in;
    logic         cur_cs, cur_wn;
    logic [1:0]   cur_addr;
    logic [31:0]  cur_wd;
    logic [W-1:0] keys;

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1; m_deb = '1; m_prev = '1; m_ec = '0; m_mask = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    // A key change is accepted once the synchronized key has disagreed with
    // the accepted value for DEB consecutive edges.
    task automatic model_edge();
        logic [W-1:0] ndeb, clr;
        if (!cur_rst) begin
            model_reset();
            return;
        end
        ndeb = m_deb;
        for (int i = 0; i < W; i++) begin
            if (m_s2[i] != m_deb[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DEB) begin
                    ndeb[i]  = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        clr = (cur_cs && !cur_wn && cur_addr == 2'd3) ? cur_wd[W-1:0] : '0;
        m_ec   = (m_ec & ~clr) | (m_prev & ~m_deb);
        if (cur_cs && !cur_wn && cur_addr == 2'd1) m_mask = cur_wd[W-1:0];
        m_prev = m_deb;
        m_deb  = ndeb;
        m_s2   = m_s1;
        m_s1   = cur_in;
    endtask

    // One clock cycle: advance the model past the edge, then apply new inputs
    // and queue what the DUT must show during this cycle.
    task automatic cyc(input logic rst, input logic cs, input logic wn,
                       input logic [1:0] addr, input logic [31:0] wd);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        reset_n = rst; chipselect = cs; write_n = wn; address = addr;
        writedata = wd; in_port = keys;
        cur_rst = rst; cur_cs = cs; cur_wn = wn; cur_addr = addr;
        cur_wd = wd; cur_in = keys;
        if (!rst) model_reset();
        e.rd_valid = cs && wn;
        case (addr)
            2'd0:    e.rd = 32'(m_deb);
            2'd1:    e.rd = 32'(m_mask);
            2'd3:    e.rd = 32'(m_ec);
            default: e.rd = 32'd0;
        endcase
        e.irq = |(m_ec & m_mask);
        exp_q.push_back(e);
    endtask

    task automatic rd(input logic [1:0] addr);
        cyc(1'b1, 1'b1, 1'b1, addr, 32'd0);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] wd);
        cyc(1'b1, 1'b1, 1'b0, addr, wd);
    endtask

    task automatic rd_n(input logic [1:0] addr, input int n);
        for (int i = 0; i < n; i++) rd(addr);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (irq !== e.irq) begin
                errors++;
                $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, e.irq);
            end
            if (e.rd_valid) begin
                checks++;
                if (readdata !== e.rd) begin
                    errors++;
                    $display("FAIL readdata addr=%0d t=%0t got=%h exp=%h",
                             address, $time, readdata, e.rd);
                end
            end
        end
    end

    initial begin
        logic found;
        keys = '1;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0;
        writedata = '0; in_port = '1;
        cur_rst = 1'b0; cur_cs = 1'b0; cur_wn = 1'b1; cur_addr = '0;
        cur_wd = '0; cur_in = '1;
        model_reset();

        // Reset values visible while reset is held.
        cyc(1'b0, 1'b1, 1'b1, 2'd0, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 2'd1, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 2'd3, 32'd0);
        rd_n(2'd0, 2);

        // Clean press of bit0.
        keys = 4'hE;
        rd_n(2'd0, 8);
        rd_n(2'd3, 2);
        wr(2'd3, 32'h1);

        // Bounce rejection on bit0.
        keys = 4'hF;
        rd_n(2'd0, 8);
        for (int r = 0; r < 3; r++) begin
            keys = 4'hE; rd(2'd0); rd(2'd3);
            keys = 4'hF; rd(2'd0); rd(2'd3);
        end
        rd_n(2'd3, 6);

        // Interrupt masking and clearing.
        wr(2'd1, 32'h2);
        keys = 4'hD;
        rd_n(2'd3, 9);
        wr(2'd3, 32'h2);
        rd_n(2'd3, 2);
        keys = 4'hF;
        rd_n(2'd0, 8);
        keys = 4'hE;
        rd_n(2'd3, 9);
        keys = 4'hF;
        rd_n(2'd0, 8);
        wr(2'd3, 32'hF);

        // Simultaneous set and clear on bit2.
        keys = 4'hB;
        rd_n(2'd3, 9);
        keys = 4'hF;
        rd_n(2'd0, 8);
        keys = 4'hB;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if ((m_prev & ~m_deb) & 4'h4) begin
                wr(2'd3, 32'h4);
                found = 1'b1;
            end else begin
                rd(2'd3);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL set_clear_window got=none exp=press_on_bit2");
        end
        rd_n(2'd3, 2);
        keys = 4'hF;
        rd_n(2'd0, 8);
        wr(2'd3, 32'hF);

        // Press and release of bit3: one capture, addr2 zero, addr0 read-only.
        keys = 4'h7;
        rd_n(2'd0, 8);
        keys = 4'hF;
        rd_n(2'd3, 9);
        rd(2'd2);
        wr(2'd0, 32'h0);
        wr(2'd2, 32'hF);
        rd(2'd0);
        rd(2'd2);
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 32'hF);
        rd(2'd3);
        wr(2'd3, 32'hF);

        // Reset in the middle of a bit0 debounce count.
        wr(2'd1, 32'h1);
        keys = 4'hE;
        rd_n(2'd0, 4);
        cyc(1'b0, 1'b1, 1'b1, 2'd3, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 2'd1, 32'd0);
        rd_n(2'd0, 8);
        rd_n(2'd3, 3);
        keys = 4'hF;
        rd_n(2'd0, 8);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [1:0]  a;
            logic [31:0] d;
            if ($urandom_range(7) == 0) keys = keys ^ W'(1 << $urandom_range(W - 1));
            a = 2'($urandom_range(3));
            d = $urandom;
            if ($urandom_range(399) == 0)
                cyc(1'b0, 1'b1, 1'b1, a, d);
            else
                cyc(1'b1, 1'($urandom_range(1)), $urandom_range(3) != 0, a, d);
        end

        cyc(1'b1, 1'b0, 1'b1, 2'd0, 32'd0);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
